// File: rtl/s1494_pkg.sv
// Shared constants and types for the s1494 state bank and its scan register.
package s1494_pkg;

  // Default widths and reset value.
  localparam int unsigned DEF_W_PI  = 7;
  localparam int unsigned DEF_W_ST  = 6;
  localparam int unsigned DEF_CNT_W = 16;
  localparam logic [DEF_W_ST-1:0] DEF_RESET_ST = 6'b000000;

  // Controller step sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions of the primary inputs inside pi_q.
  localparam int unsigned V0 = 0;
  localparam int unsigned V1 = 1;
  localparam int unsigned V2 = 2;
  localparam int unsigned V3 = 3;
  localparam int unsigned V4 = 4;
  localparam int unsigned V5 = 5;
  localparam int unsigned V6 = 6;

  // Bit positions of the state bits inside st_q / ns.
  localparam int unsigned V7  = 0;
  localparam int unsigned V8  = 1;
  localparam int unsigned V9  = 2;
  localparam int unsigned V10 = 3;
  localparam int unsigned V11 = 4;
  localparam int unsigned V12 = 5;

endpackage

// File: rtl/s1494_scan_reg.sv
// State register with parallel load from the next-state slices and a
// serial shift path (LSB in, MSB out). Load and shift are never requested
// together by the controller; load takes priority if they ever are.
module s1494_scan_reg
  import s1494_pkg::*;
#(
  parameter int unsigned W         = DEF_W_ST,
  parameter logic [W-1:0] RESET_VAL = DEF_RESET_ST
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  input  logic         si,
  output logic [W-1:0] q,
  output logic         so
);

  // Parallel commit of next state, or one-bit shift toward the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[W-2:0], si};
    end
  end

  assign so = q[W-1];

endmodule

// File: rtl/s1494_state_bank.sv
// Sequential wrapper for the s1494 controller: registers the primary inputs,
// holds the state bits, commits the slices' next state once per step and
// counts committed steps.
//
// Handshake: a transfer happens on a rising CK edge where valid and ready are
// both high. Input side: pi is taken when in_valid && in_ready; in_ready does
// not depend on in_valid. Output side: out_valid stays high with st_q frozen
// until a cycle with out_ready high, which ends the step; out_valid does not
// depend on out_ready.
module s1494_state_bank
  import s1494_pkg::*;
#(
  parameter int unsigned W_PI  = DEF_W_PI,
  parameter int unsigned W_ST  = DEF_W_ST,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter logic [W_ST-1:0] RESET_ST = DEF_RESET_ST
) (
  input  logic             CK,
  input  logic             CLR,
  input  logic [W_PI-1:0]  pi,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W_PI-1:0]  pi_q,
  output logic [W_ST-1:0]  st_q,
  input  logic [W_ST-1:0]  ns,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
  output logic [CNT_W-1:0] step_cnt,
  output logic [1:0]       fsm_state
);

  state_t state;
  state_t state_nx;

  logic accept;
  logic do_shift;
  logic do_commit;

  // Scan only runs in IDLE and blocks acceptance; EVAL is the single commit cycle.
  assign in_ready  = (state == IDLE) && !scan_en;
  assign accept    = in_valid && in_ready;
  assign do_shift  = (state == IDLE) && scan_en;
  assign do_commit = (state == EVAL);
  assign out_valid = (state == DONE);
  assign fsm_state = state;

  // FSM state register.
  always_ff @(posedge CK or negedge CLR) begin
    if (!CLR) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: accept -> one settle cycle -> hold until consumed.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EVAL;
      EVAL:    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Primary-input register, loaded on an accepted transfer only.
  always_ff @(posedge CK or negedge CLR) begin
    if (!CLR) begin
      pi_q <= '0;
    end else if (accept) begin
      pi_q <= pi;
    end
  end

  // Committed-step counter; wraps silently.
  always_ff @(posedge CK or negedge CLR) begin
    if (!CLR) begin
      step_cnt <= '0;
    end else if (do_commit) begin
      step_cnt <= step_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  s1494_scan_reg #(
    .W         (W_ST),
    .RESET_VAL (RESET_ST)
  ) u_scan_reg (
    .clk   (CK),
    .rst_n (CLR),
    .load  (do_commit),
    .shift (do_shift),
    .d     (ns),
    .si    (scan_in),
    .q     (st_q),
    .so    (scan_out)
  );

endmodule

// File: tb/tb_s1494_state_bank.sv
// Bench for s1494_state_bank: directed steps, back-pressure, scan, counter
// wrap (on a second instance with a 4-bit counter) and mid-step reset.
module tb_s1494_state_bank;

  localparam int W = 16 + 4 + 6;  // {step_cnt, step_cnt4, st_q}

  logic        CK;
  logic        CLR;
  logic [6:0]  pi;
  logic        in_valid;
  logic [5:0]  ns;
  logic        out_ready;
  logic        scan_en;
  logic        scan_in;

  logic        in_ready, out_valid, scan_out;
  logic [6:0]  pi_q;
  logic [5:0]  st_q;
  logic [15:0] step_cnt;
  logic [1:0]  fsm_state;

  logic        in_ready4, out_valid4, scan_out4;
  logic [6:0]  pi_q4;
  logic [5:0]  st_q4;
  logic [3:0]  step_cnt4;
  logic [1:0]  fsm_state4;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_cnt;

  s1494_state_bank u_dut (
    .CK(CK), .CLR(CLR), .pi(pi), .in_valid(in_valid), .in_ready(in_ready),
    .pi_q(pi_q), .st_q(st_q), .ns(ns), .out_valid(out_valid),
    .out_ready(out_ready), .scan_en(scan_en), .scan_in(scan_in),
    .scan_out(scan_out), .step_cnt(step_cnt), .fsm_state(fsm_state)
  );

  s1494_state_bank #(.CNT_W(4)) u_dut4 (
    .CK(CK), .CLR(CLR), .pi(pi), .in_valid(in_valid), .in_ready(in_ready4),
    .pi_q(pi_q4), .st_q(st_q4), .ns(ns), .out_valid(out_valid4),
    .out_ready(out_ready), .scan_en(scan_en), .scan_in(scan_in),
    .scan_out(scan_out4), .step_cnt(step_cnt4), .fsm_state(fsm_state4)
  );

  // Clock and global time bound.
  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops on each new out_valid, checks every held cycle.
  logic         ov_prev;
  logic         have_cur;
  logic [W-1:0] cur;
  always @(negedge CK) begin
    if (!CLR) begin
      ov_prev  <= 1'b0;
      have_cur = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
          have_cur = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (out_valid && have_cur) begin
        chk("mon_st_q",      32'(st_q),      32'(cur[5:0]));
        chk("mon_step_cnt",  32'(step_cnt),  32'(cur[25:10]));
        chk("mon_st_q4",     32'(st_q4),     32'(cur[5:0]));
        chk("mon_step_cnt4", 32'(step_cnt4), 32'(cur[9:6]));
        chk("mon_out_valid4", 32'(out_valid4), 32'd1);
      end
      ov_prev <= out_valid;
    end
  end

  // One full step from IDLE; hold > 0 keeps out_ready low for hold DONE cycles
  // while a new input is offered, and checks it is not taken early.
  task automatic do_step(input logic [6:0] p, input logic [5:0] n, input int hold);
    @(posedge CK); #1;
    pi = p; in_valid = 1'b1; ns = n;
    @(negedge CK);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge CK); #1;            // accept edge
    in_valid = 1'b0; pi = ~p;
    exp_cnt = exp_cnt + 16'd1;
    exp_q.push_back({exp_cnt, exp_cnt[3:0], n});
    @(negedge CK);
    chk("pi_q_after_accept", 32'(pi_q), 32'(p));
    chk("in_ready_eval", 32'(in_ready), 32'd0);
    chk("out_valid_eval", 32'(out_valid), 32'd0);
    @(posedge CK); #1;            // commit edge
    ns = ~n;
    if (hold > 0) begin
      out_ready = 1'b0; in_valid = 1'b1; pi = 7'h2A;
      for (int i = 0; i < hold; i++) begin
        @(negedge CK);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge CK); #1;
        ns = ns ^ 6'h15;
      end
      out_ready = 1'b1;
      @(negedge CK);
      chk("bp_release_in_ready", 32'(in_ready), 32'd0);
      @(posedge CK); #1;          // back to IDLE
      @(negedge CK);
      chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
      chk("bp_no_early_accept", 32'(pi_q), 32'(p));
      chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b0;
    end else begin
      @(negedge CK);
      chk("done_in_ready", 32'(in_ready), 32'd0);
      @(posedge CK); #1;
      @(negedge CK);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
    end
  endtask

  logic [5:0] scan_bits;
  logic [5:0] scan_out_exp;

  initial begin
    CLR = 1'b1; pi = '0; in_valid = 1'b0; ns = '0;
    out_ready = 1'b1; scan_en = 1'b0; scan_in = 1'b0;
    exp_cnt = '0;

    // Asynchronous reset mid-cycle, checked while still asserted.
    #2 CLR = 1'b0;
    #1;
    chk("rst_st_q", 32'(st_q), 32'd0);
    chk("rst_pi_q", 32'(pi_q), 32'd0);
    chk("rst_step_cnt", 32'(step_cnt), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_scan_out", 32'(scan_out), 32'd0);
    chk("rst_fsm", 32'(fsm_state), 32'd0);
    @(negedge CK);
    CLR = 1'b1;

    // Single step.
    do_step(7'h55, 6'b101010, 0);
    // Back-pressure for 5 cycles with in_valid high and ns toggling.
    do_step(7'h13, 6'b010011, 5);

    // Scan: prior state 010011 seen MSB-first on scan_out.
    scan_bits    = 6'b001101;     // scan_in order bit0..bit5 = 1,0,1,1,0,0
    scan_out_exp = 6'b110010;     // scan_out order bit0..bit5 = 0,1,0,0,1,1
    @(posedge CK); #1;
    in_valid = 1'b1; pi = 7'h7E;
    for (int i = 0; i < 6; i++) begin
      scan_en = 1'b1; scan_in = scan_bits[i];
      @(negedge CK);
      chk("scan_out_bit", 32'(scan_out), 32'(scan_out_exp[i]));
      chk("scan_in_ready", 32'(in_ready), 32'd0);
      @(posedge CK); #1;
    end
    scan_en = 1'b0; in_valid = 1'b0;
    @(negedge CK);
    chk("scan_st_q", 32'(st_q), 32'b101100);
    chk("scan_pi_q_hold", 32'(pi_q), 32'h13);
    chk("scan_step_cnt", 32'(step_cnt), 32'(exp_cnt));
    chk("scan_fsm_idle", 32'(fsm_state), 32'd0);

    // Fourteen more steps: 16 commits total, 4-bit counter wraps to 0.
    for (int i = 0; i < 14; i++) begin
      do_step(7'(i * 5 + 1), 6'(i * 3 + 7), 0);
    end
    @(negedge CK);
    chk("wrap_step_cnt4", 32'(step_cnt4), 32'd0);
    chk("wrap_step_cnt", 32'(step_cnt), 32'd16);

    // Abort: reset during EVAL with ns = 3F.
    @(posedge CK); #1;
    pi = 7'h66; in_valid = 1'b1; ns = 6'h3F;
    @(posedge CK); #1;            // accept; now in EVAL
    in_valid = 1'b0;
    #2 CLR = 1'b0;
    #1;
    chk("abort_st_q", 32'(st_q), 32'd0);
    chk("abort_fsm", 32'(fsm_state), 32'd0);
    chk("abort_pi_q", 32'(pi_q), 32'd0);
    chk("abort_step_cnt", 32'(step_cnt), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    @(negedge CK);
    CLR = 1'b1;
    exp_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CK);
      chk("abort_no_out_valid", 32'(out_valid), 32'd0);
    end

    // A fresh step after the abort counts from zero.
    do_step(7'h7F, 6'h21, 0);
    repeat (2) @(negedge CK);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/s1494_state_bank.md
# s1494_state_bank

Sequential wrapper for the s1494 controller: holds the six state bits (v7..v12) and the registered primary-input vector (v0..v6) that drive the combinational next-state slices. It captures their next-state bits (including the n60 slice) once per step under a valid/ready handshake. It sits directly downstream of the slices, and its registered outputs feed back into them. It adds a serial scan path on the state bits and a step counter for the bench.

## Interface
- W_PI, 7, primary-input width ({v6..v0})
- W_ST, 6, state width ({v12..v7})
- CNT_W, 16, step-counter width
- RESET_ST, 6'b000000, state value loaded on reset
- CK  in  1  clock, rising edge
- CLR  in  1  asynchronous active-low reset; also routed unchanged to the slices as their clear input
- pi  in  W_PI  primary-input vector offered upstream
- in_valid  in  1  pi is valid
- in_ready  out  1  block accepts pi this cycle
- pi_q  out  W_PI  registered inputs to slices (bit i = v_i)
- st_q  out  W_ST  state to slices (bit i = v(7+i))
- ns  in  W_ST  next-state bits from the slices (bit i = next v(7+i))
- out_valid  out  1  st_q holds a freshly committed state
- out_ready  in  1  consumer accepts the committed state
- scan_en  in  1  serial shift of st_q requested
- scan_in  in  1  serial data into st_q[0]
- scan_out  out  1  equals st_q[W_ST-1]
- step_cnt  out  CNT_W  committed steps, modulo 2^CNT_W

## Operation
- FSM states are IDLE, EVAL and DONE.
- IDLE:
  - in_ready = !scan_en.
  - When in_valid && in_ready, pi_q <= pi and the FSM goes to EVAL.
  - When scan_en, st_q <= {st_q[W_ST-2:0], scan_in} each cycle, pi_q holds, and step_cnt holds.
- EVAL:
  - Lasts exactly one cycle; the slices settle on the new pi_q/st_q.
  - At its closing edge, st_q <= ns, step_cnt <= step_cnt+1 (wraps to 0), and the FSM goes to DONE.
- DONE:
  - out_valid = 1; st_q and pi_q hold.
  - When out_ready, the FSM goes to IDLE.
- in_ready = 0 in EVAL and DONE.
- scan_en outside IDLE is ignored; shifting starts on the first IDLE cycle in which scan_en = 1.
- ns is sampled only at the EVAL closing edge. Its value at any other time is don't-care.
- The block does no logic on ns; all next-state functions live in the slices.

## Timing
- Reset (CLR low, asynchronous) gives:
  - FSM = IDLE, st_q = RESET_ST, pi_q = 0, step_cnt = 0, out_valid = 0, in_ready = 1 (combinational, scan_en permitting), scan_out = RESET_ST[W_ST-1].
- Deassertion of CLR is synchronised externally; the first active edge after release may accept input.
- Latency for an accept at edge k:
  - pi_q is updated at k.
  - st_q and step_cnt are updated at k+1.
  - out_valid is high after k+1.
- Minimum step period is 3 cycles (accept, EVAL, DONE with out_ready = 1).
- out_valid is held until out_ready, with no data change while held.
- in_valid && scan_en in IDLE: scan wins, nothing is accepted, and pi is not consumed.
- When out_ready = 1 in DONE and in_valid = 1 in the same cycle, the new input is NOT accepted that cycle; it is accepted on the following IDLE cycle.
- CLR asserted mid-EVAL or mid-DONE aborts the step immediately: no commit, and all registers take their reset values.
- step_cnt wraps from 2^CNT_W-1 to 0 without a flag.

## Structure
- A shared package `s1494_pkg` holds:
  - the W_PI/W_ST defaults;
  - the FSM state enum (2-bit, IDLE=0, EVAL=1, DONE=2);
  - the RESET_ST constant;
  - named bit indices V0..V12.
- A sub-module `s1494_scan_reg` is natural: a W_ST-bit register with parallel load (ns), serial shift (scan_in/scan_out) and async reset to RESET_ST.
- The FSM, pi_q register and step counter stay in the top module.

## Test plan
- Reset: pulse CLR low mid-cycle -> immediately st_q = 0, pi_q = 0, step_cnt = 0, out_valid = 0, in_ready = 1.
- Single step: pi = 7'h55, in_valid = 1 for one cycle, ns driven to 6'b101010 -> pi_q = 7'h55 after edge 1; st_q = 6'b101010, out_valid = 1 and step_cnt = 1 after edge 2.
- Back-pressure: out_ready = 0 for 5 cycles in DONE while in_valid = 1 and ns toggles -> st_q stable, in_ready = 0, no second accept until the cycle after out_ready rises.
- Scan: in IDLE, scan_en = 1 for 6 cycles with scan_in = 1,0,1,1,0,0 -> st_q = 6'b101100; scan_out shows the prior state MSB-first; step_cnt unchanged; in_ready = 0 throughout.
- Counter wrap: with CNT_W = 4, complete 16 steps -> step_cnt returns to 0 on the 16th commit.
- Abort: assert CLR during EVAL with ns = 6'h3F -> st_q = 0 and FSM = IDLE, with no out_valid pulse.
